single_port_ram_ctrl: RTL and testbench

Parametrised single-port synchronous RAM, successor to the basic 8-bit single-port RAM. Adds byte-enable writes, a selectable read-during-write mode, an optional output register, a read-valid strobe and a reset-triggered clear sequencer that zeroes the array. Used as the generic on-chip storage macro behind buffers and register files in the memory subsystem.

---
 rtl/single_port_ram_ctrl.sv | 171 +++++++++++++++++
 tb/tb_single_port_ram_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/single_port_ram_ctrl.sv
// single_port_ram_ctrl: parametrised single-port synchronous RAM with byte-enable writes,
// selectable read-during-write behaviour, optional output register, read-valid strobe and a
// post-reset clear sequencer that zeroes the whole array.
//
// Ports:
//   clk_i      clock, all state on rising edge
//   rst_i      asynchronous reset, active-high (array contents untouched by reset itself)
//   en_i       access request, ignored while busy_o=1
//   we_i       1 = write, 0 = read
//   be_i       byte-lane write enables
//   addr_i     word address
//   data_i     write data
//   q_o        read data, holds until the next result
//   q_valid_o  one-cycle strobe, q_o carries a new result
//   busy_o     clear sequence in progress, accesses are dropped
module single_port_ram_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_MODE      = 0,
    parameter int unsigned OUT_REG        = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             en_i,
    input  logic                             we_i,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]            addr_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    output logic [DATA_WIDTH-1:0]            q_o,
    output logic                             q_valid_o,
    output logic                             busy_o
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    localparam state_e ResetState = (CLEAR_ON_RESET != 0) ? StClear : StIdle;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [Depth];

    logic                    busy;
    logic                    accept;
    logic                    clear_we;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

    // ---------------------------------------------------------------- clear sequencer FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy   = (state_q == StClear);
    assign busy_o = busy;

    // Reset gates array writes so asserting rst never disturbs stored contents.
    assign accept   = en_i & ~busy & ~rst_i;
    assign clear_we = busy & ~rst_i;

    // ---------------------------------------------------------------- array
    assign old_word = mem_q[addr_i];

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be_i[i]) begin
                merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_we) begin
            mem_q[cnt_q] <= '0;
        end else if (accept && we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read stage
    // Data register only moves on a new result so q holds across idle cycles.
    always_comb begin
        s1_valid_d = 1'b0;
        s1_data_d  = s1_data_q;
        if (accept) begin
            if (!we_i) begin
                s1_valid_d = 1'b1;
                s1_data_d  = old_word;
            end else if (READ_MODE == 0) begin
                s1_valid_d = 1'b1;
                s1_data_d  = old_word;
            end else if (READ_MODE == 1) begin
                s1_valid_d = 1'b1;
                s1_data_d  = merged_word;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // ---------------------------------------------------------------- optional output stage
    if (OUT_REG != 0) begin : g_out_reg
        logic                  q_valid_q;
        logic [DATA_WIDTH-1:0] q_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                q_valid_q <= 1'b0;
                q_q       <= '0;
            end else begin
                q_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    q_q <= s1_data_q;
                end
            end
        end

        assign q_o       = q_q;
        assign q_valid_o = q_valid_q;
    end else begin : g_no_out_reg
        assign q_o       = s1_data_q;
        assign q_valid_o = s1_valid_q;
    end

endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// Bench for single_port_ram_ctrl: three instances with different configurations share one
// stimulus stream and are each compared against a behavioural model of the memory.
//   inst 0: READ_MODE=0, OUT_REG=1, CLEAR_ON_RESET=1
//   inst 1: READ_MODE=1, OUT_REG=0, CLEAR_ON_RESET=1
//   inst 2: READ_MODE=2, OUT_REG=1, CLEAR_ON_RESET=0
module tb_single_port_ram_ctrl;

    localparam int NI    = 3;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] data;

    logic [31:0] q_w    [NI];
    logic        qv_w   [NI];
    logic        busy_w [NI];

    always #5 clk = ~clk;

    single_port_ram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
        .READ_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
        .data_i(data), .q_o(q_w[0]), .q_valid_o(qv_w[0]), .busy_o(busy_w[0])
    );

    single_port_ram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
        .READ_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
        .data_i(data), .q_o(q_w[1]), .q_valid_o(qv_w[1]), .busy_o(busy_w[1])
    );

    single_port_ram_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .BYTE_WIDTH(8),
        .READ_MODE(2), .OUT_REG(1), .CLEAR_ON_RESET(0)
    ) u_dut2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .we_i(we), .be_i(be), .addr_i(addr),
        .data_i(data), .q_o(q_w[2]), .q_valid_o(qv_w[2]), .busy_o(busy_w[2])
    );

    // Per-instance configuration as seen by the model.
    int rm_c [NI] = '{0, 1, 2};
    int lat_c[NI] = '{2, 1, 2};
    int cl_c [NI] = '{1, 1, 0};

    // Model state: array contents with per-byte "known" flags, clear countdown, result line.
    logic [31:0] mem_m [NI][DEPTH];
    logic [3:0]  kn_m  [NI][DEPTH];
    int          clear_left [NI];
    logic        pend_v [NI];
    logic [31:0] pend_d [NI];
    logic [3:0]  pend_k [NI];
    logic [31:0] q_e    [NI];
    logic [3:0]  q_k    [NI];
    logic        qv_e   [NI];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[i][a] = 32'h0;
                kn_m[i][a]  = 4'h0;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            clear_left[i] = (cl_c[i] != 0) ? DEPTH : 0;
            pend_v[i] = 1'b0;
            pend_d[i] = 32'h0;
            pend_k[i] = 4'hF;
            q_e[i]    = 32'h0;
            q_k[i]    = 4'hF;
            qv_e[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic        rv;
        logic [31:0] rd, old_w, mrg;
        logic [3:0]  rk, old_k, mk;
        for (int i = 0; i < NI; i++) begin
            rv = 1'b0;
            rd = 32'h0;
            rk = 4'h0;
            if (clear_left[i] > 0) begin
                mem_m[i][DEPTH - clear_left[i]] = 32'h0;
                kn_m[i][DEPTH - clear_left[i]]  = 4'hF;
                clear_left[i]--;
            end else if (en) begin
                old_w = mem_m[i][addr];
                old_k = kn_m[i][addr];
                mrg   = (old_w & ~lane_mask(be)) | (data & lane_mask(be));
                mk    = old_k | be;
                if (!we) begin
                    rv = 1'b1; rd = old_w; rk = old_k;
                end else begin
                    if (rm_c[i] == 0) begin
                        rv = 1'b1; rd = old_w; rk = old_k;
                    end else if (rm_c[i] == 1) begin
                        rv = 1'b1; rd = mrg; rk = mk;
                    end
                    mem_m[i][addr] = mrg;
                    kn_m[i][addr]  = mk;
                end
            end
            if (lat_c[i] == 2) begin
                qv_e[i] = pend_v[i];
                if (pend_v[i]) begin
                    q_e[i] = pend_d[i];
                    q_k[i] = pend_k[i];
                end
                pend_v[i] = rv; pend_d[i] = rd; pend_k[i] = rk;
            end else begin
                qv_e[i] = rv;
                if (rv) begin
                    q_e[i] = rd;
                    q_k[i] = rk;
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare just after, return at the falling edge.
    task automatic step();
        logic [31:0] m;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        for (int i = 0; i < NI; i++) begin
            m = lane_mask(q_k[i]);
            chk($sformatf("q[%0d]", i), q_w[i] & m, q_e[i] & m);
            chk($sformatf("q_valid[%0d]", i), {31'b0, qv_w[i]}, {31'b0, qv_e[i]});
            chk($sformatf("busy[%0d]", i), {31'b0, busy_w[i]},
                {31'b0, (clear_left[i] > 0) ? 1'b1 : 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic op(input logic e, input logic w, input logic [3:0] b,
                      input logic [5:0] a, input logic [31:0] d);
        en = e; we = w; be = b; addr = a; data = d;
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; be = 4'h0; addr = 6'd0; data = 32'h0;
        model_init();
        model_reset();
        @(negedge clk);
        step();
        step();

        // Clear interrupted by reset after 20 cycles; writes issued meanwhile are dropped
        // by the clearing instances.
        rst = 1'b0;
        for (int c = 0; c < 20; c++) op(1'b1, 1'b1, 4'hF, 6'($urandom), $urandom);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < DEPTH + 4; c++) op(1'b1, 1'b1, 4'($urandom), 6'($urandom), $urandom);

        // Read back every address.
        for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, 4'h0, 6'(a), 32'h0);
        for (int c = 0; c < 3; c++) op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);

        // Byte-enable merge.
        op(1'b1, 1'b1, 4'hF, 6'd5, 32'hDEADBEEF);
        op(1'b1, 1'b1, 4'h5, 6'd5, 32'h11223344);
        op(1'b1, 1'b0, 4'h0, 6'd5, 32'h0);
        for (int c = 0; c < 3; c++) op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        for (int i = 0; i < NI; i++) chk($sformatf("merge_q[%0d]", i), q_w[i], 32'hDE22BE44);

        // Read-during-write modes.
        op(1'b1, 1'b1, 4'hF, 6'd3, 32'hAAAAAAAA);
        op(1'b1, 1'b1, 4'hF, 6'd3, 32'h55555555);
        for (int c = 0; c < 3; c++) op(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
        chk("rdw_first", q_w[0], 32'hAAAAAAAA);
        chk("wr_first", q_w[1], 32'h55555555);
        chk("no_change", q_w[2], 32'hDE22BE44);

        // Back-to-back reads on the unregistered-output instance.
        for (int a = 0; a < 4; a++) op(1'b1, 1'b1, 4'hF, 6'(a), 32'h10 + 32'(a));
        for (int a = 0; a < 4; a++) begin
            op(1'b1, 1'b0, 4'h0, 6'(a), 32'h0);
            chk("b2b_q", q_w[1], 32'h10 + 32'(a));
            chk("b2b_valid", {31'b0, qv_w[1]}, 32'h1);
        end

        // Top address, then idle hold.
        op(1'b1, 1'b1, 4'hF, 6'd63, 32'h0000FFFF);
        op(1'b1, 1'b0, 4'h0, 6'd63, 32'h0);
        for (int c = 0; c < 5; c++) op(1'b0, 1'b1, 4'hF, 6'($urandom), $urandom);
        for (int i = 0; i < NI; i++) chk($sformatf("top_q[%0d]", i), q_w[i], 32'h0000FFFF);

        // Random traffic, half of it concentrated on a few addresses for read-after-write hits.
        for (int c = 0; c < 3000; c++) begin
            op(($urandom_range(3, 0) != 0), 1'($urandom), 4'($urandom),
               ($urandom_range(1, 0) != 0) ? 6'($urandom_range(7, 0)) : 6'($urandom),
               $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
